// File: rtl/reg_write_16_4b_pkg.sv
// Shared sizes and FSM encoding for the 16 x 4-bit register bank write side.
package reg_write_16_4b_pkg;

    localparam int NUM_REGS = 16;
    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/reg_write_16_4b_decoder_4_16.sv
// Combinational 4-to-16 one-hot decoder; all outputs low when disabled.
module decoder_4_16
    import reg_write_16_4b_pkg::*;
(
    input  logic                i_en,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [NUM_REGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        if (i_en) begin
            o_onehot[i_addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_write_16_4b.sv
// Write side of the 16 x 4-bit register bank: single-cycle writes plus a
// one-entry-per-cycle clear sweep, with the whole bank exposed as a flat bus.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | accepting writes; clr starts a sweep at entry 0
// ST_CLEAR | zeroing entry r_cnt each edge; writes and clr ignored
module reg_write_16_4b
    import reg_write_16_4b_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_W-1:0]            wr_addr,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic                         clr,
    output logic                         busy,
    output logic                         wr_ack,
    output logic [NUM_REGS*DATA_W-1:0]   q
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]   w_cnt_nxt;
    logic                r_ack;
    logic [DATA_W-1:0]   r_regs [NUM_REGS];

    logic                w_accept;
    logic                w_clearing;
    logic [NUM_REGS-1:0] w_wr_oh;
    logic [NUM_REGS-1:0] w_clr_oh;
    logic [NUM_REGS-1:0] w_load;
    logic [DATA_W-1:0]   w_load_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_ack   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ack   <= w_accept;
        end
    end

    // clr has priority over a simultaneous write in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (clr) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end else begin
                    w_accept = wr_en;
                end
            end
            ST_CLEAR: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign w_clearing = (r_state == ST_CLEAR);

    decoder_4_16 u_dec_wr (
        .i_en     (w_accept),
        .i_addr   (wr_addr),
        .o_onehot (w_wr_oh)
    );

    decoder_4_16 u_dec_clr (
        .i_en     (w_clearing),
        .i_addr   (r_cnt),
        .o_onehot (w_clr_oh)
    );

    // The two one-hot vectors are never active together, so state alone picks the data.
    assign w_load      = w_wr_oh | w_clr_oh;
    assign w_load_data = w_clearing ? '0 : wr_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                r_regs[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (w_load[k]) begin
                    r_regs[k] <= w_load_data;
                end
            end
        end
    end

    assign busy   = (r_state == ST_CLEAR);
    assign wr_ack = r_ack;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_q
        assign q[g*DATA_W +: DATA_W] = r_regs[g];
    end

endmodule

// File: tb/tb_reg_write_16_4b.sv
// Self-checking bench: behavioural bank model checked every cycle, plus
// directed scenarios with literal expectations and a randomized phase.
module tb_reg_write_16_4b;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        wr_en   = 1'b0;
    logic        clr     = 1'b0;
    logic [3:0]  wr_addr = 4'h0;
    logic [3:0]  wr_data = 4'h0;
    logic        busy;
    logic        wr_ack;
    logic [63:0] q;

    int errors = 0;
    int checks = 0;

    // Model: bank contents, sweep position (-1 when not sweeping), ack flag.
    logic [3:0] m_reg [16];
    int         m_sweep = -1;
    logic       m_ack   = 1'b0;

    reg_write_16_4b dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .clr     (clr),
        .busy    (busy),
        .wr_ack  (wr_ack),
        .q       (q)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] model_q();
        logic [63:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            v[4*k +: 4] = m_reg[k];
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 16; k++) m_reg[k] = 4'h0;
            m_sweep = -1;
            m_ack   = 1'b0;
        end else if (m_sweep >= 0) begin
            m_reg[m_sweep] = 4'h0;
            m_sweep = m_sweep + 1;
            if (m_sweep == 16) m_sweep = -1;
            m_ack = 1'b0;
        end else if (clr) begin
            m_sweep = 0;
            m_ack   = 1'b0;
        end else if (wr_en) begin
            m_reg[wr_addr] = wr_data;
            m_ack = 1'b1;
        end else begin
            m_ack = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("model_q", q, model_q());
        chk("model_busy", {63'd0, busy}, {63'd0, (m_sweep >= 0)});
        chk("model_ack", {63'd0, wr_ack}, {63'd0, m_ack});
    end

    task automatic drive(input logic e, input logic c, input logic [3:0] a, input logic [3:0] d);
        wr_en   = e;
        clr     = c;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic fill(input logic [3:0] v);
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, 4'(k), v);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
    endtask

    initial begin
        int          acks;
        int          busycnt;
        logic [63:0] ones;
        ones = '1;

        // Reset held with random inputs.
        rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
        @(negedge clk);
        chk("rst_q", q, 64'h0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_ack", {63'd0, wr_ack}, 64'd0);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        rst = 1'b0;
        @(negedge clk);

        // First write after reset.
        drive(1'b1, 1'b0, 4'd3, 4'h9);
        @(negedge clk);
        chk("first_wr_q", q, 64'h0000_0000_0000_9000);
        chk("first_wr_ack", {63'd0, wr_ack}, 64'd1);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        chk("first_wr_ack_low", {63'd0, wr_ack}, 64'd0);

        // Back-to-back write burst, entry k gets 15-k.
        acks = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1'b1, 1'b0, 4'(k), 4'(15 - k));
            @(negedge clk);
            if (wr_ack) acks++;
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        chk("burst_q", q, 64'h0123_4567_89AB_CDEF);
        chk("burst_acks", 64'(acks), 64'd16);

        // Clear sweep over an all-F bank.
        fill(4'hF);
        chk("fill_f", q, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, 1'b1, 4'h0, 4'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        chk("sweep_start_busy", {63'd0, busy}, 64'd1);
        busycnt = 1;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            chk("sweep_q", q, (n == 16) ? 64'h0 : (ones << (4 * n)));
            if (busy) busycnt++;
        end
        chk("sweep_busy_cycles", 64'(busycnt), 64'd16);
        chk("sweep_end_busy", {63'd0, busy}, 64'd0);

        // Contention: clr with write, writes during busy, clr re-pulse mid-sweep.
        drive(1'b1, 1'b0, 4'd7, 4'h3);
        @(negedge clk);
        drive(1'b1, 1'b1, 4'd7, 4'h5);
        @(negedge clk);
        chk("contend_ack", {63'd0, wr_ack}, 64'd0);
        chk("contend_busy", {63'd0, busy}, 64'd1);
        busycnt = 1;
        for (int i = 0; i < 40; i++) begin
            if (busycnt == 8) drive(1'b0, 1'b1, 4'h0, 4'h0);
            else drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(1, 15)));
            @(negedge clk);
            if (!busy) break;
            busycnt++;
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        chk("contend_busy_cycles", 64'(busycnt), 64'd16);
        chk("contend_entry7", {60'd0, q[31:28]}, 64'd0);
        chk("contend_q", q, 64'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 99) < 4),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        repeat (20) @(negedge clk);

        // Asynchronous reset mid-sweep.
        fill(4'hA);
        chk("fill_a", q, 64'hAAAA_AAAA_AAAA_AAAA);
        drive(1'b0, 1'b1, 4'h0, 4'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        repeat (6) @(negedge clk);
        chk("mid_sweep_busy", {63'd0, busy}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_q", q, 64'h0);
        chk("async_rst_busy", {63'd0, busy}, 64'd0);
        chk("async_rst_ack", {63'd0, wr_ack}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 4'd15, 4'hC);
        @(negedge clk);
        chk("post_rst_q", q, 64'hC000_0000_0000_0000);
        chk("post_rst_ack", {63'd0, wr_ack}, 64'd1);
        drive(1'b0, 1'b0, 4'h0, 4'h0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
